// File: rtl/display_mux.sv
// Two-digit time-multiplexed seven-segment driver with programmable dead time between digits.
// Define LEAD_ZERO_BLANK_EN to darken digit 1 (tens) when it latches zero.
module display_mux #(
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_div,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [6:0] seg,
    output logic       an0,
    output logic       an1
);

    typedef enum logic [1:0] {BLANK_TO0, SHOW0, BLANK_TO1, SHOW1} state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             clk_div_q;
    logic [3:0]       digit;
    logic             swap_evt;
    logic             blank_done;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Digit 1 is the tens position; optionally suppress a leading zero.
    function automatic logic [6:0] decode1(input logic [3:0] v);
`ifdef LEAD_ZERO_BLANK_EN
        decode1 = (v == 4'h0) ? SEG_OFF : decode(v);
`else
        decode1 = decode(v);
`endif
    endfunction

    assign swap_evt   = clk_div ^ clk_div_q;
    assign blank_done = (BLANK_CYCLES == 0) || (cnt == CNT_W'(BLANK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= BLANK_TO0;
            cnt       <= '0;
            clk_div_q <= 1'b0;
            digit     <= 4'h0;
            seg       <= SEG_OFF;
            an0       <= 1'b1;
            an1       <= 1'b1;
        end else begin
            clk_div_q <= clk_div;
            case (state)
                SHOW0: begin
                    seg <= decode(digit);
                    if (swap_evt) begin
                        // With no dead time the enables hand over in one edge.
                        if (BLANK_CYCLES == 0) begin
                            state <= SHOW1;
                            digit <= s1;
                            seg   <= decode1(s1);
                            an0   <= 1'b1;
                            an1   <= 1'b0;
                        end else begin
                            state <= BLANK_TO1;
                            cnt   <= '0;
                            seg   <= SEG_OFF;
                            an0   <= 1'b1;
                            an1   <= 1'b1;
                        end
                    end
                end
                SHOW1: begin
                    seg <= decode1(digit);
                    if (swap_evt) begin
                        if (BLANK_CYCLES == 0) begin
                            state <= SHOW0;
                            digit <= s0;
                            seg   <= decode(s0);
                            an0   <= 1'b0;
                            an1   <= 1'b1;
                        end else begin
                            state <= BLANK_TO0;
                            cnt   <= '0;
                            seg   <= SEG_OFF;
                            an0   <= 1'b1;
                            an1   <= 1'b1;
                        end
                    end
                end
                // Swap edges seen while blanking are dropped, not queued.
                BLANK_TO1: begin
                    if (blank_done) begin
                        state <= SHOW1;
                        cnt   <= '0;
                        digit <= s1;
                        seg   <= decode1(s1);
                        an1   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (blank_done) begin
                        state <= SHOW0;
                        cnt   <= '0;
                        digit <= s0;
                        seg   <= decode(s0);
                        an0   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux: one instance with 16-cycle dead time, one with none.
module tb_display_mux;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, div_a, div_b;
    logic [3:0] s0_a, s1_a, s0_b, s1_b;
    logic [6:0] seg_a, seg_b;
    logic       an0_a, an1_a, an0_b, an1_b;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    // Expected {an0, an1, seg} at a given cycle for instance a (0) or b (1).
    typedef struct {
        int         cyc;
        bit         dut;
        logic [8:0] val;
        string      name;
    } exp_t;
    exp_t sb[$];

    localparam logic [8:0] BLANK = {2'b11, 7'b1111111};

    display_mux #(.BLANK_CYCLES(16), .CNT_W(8)) dut_a (
        .clk(clk), .reset(rst_a), .clk_div(div_a), .s0(s0_a), .s1(s1_a),
        .seg(seg_a), .an0(an0_a), .an1(an1_a)
    );

    display_mux #(.BLANK_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(rst_b), .clk_div(div_b), .s0(s0_b), .s1(s1_b),
        .seg(seg_b), .an0(an0_b), .an1(an1_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Both enables low at once is never legal on either instance.
    always @(negedge clk) begin
        if (an0_a === 1'b0 && an1_a === 1'b0) begin
            total++;
            $display("FAIL excl_a cyc=%0d an0=%b an1=%b required not both 0", cyc, an0_a, an1_a);
        end
        if (an0_b === 1'b0 && an1_b === 1'b0) begin
            total++;
            $display("FAIL excl_b cyc=%0d an0=%b an1=%b required not both 0", cyc, an0_b, an1_b);
        end
    end

    function automatic logic [8:0] on0(input logic [6:0] s);
        return {2'b01, s};
    endfunction

    function automatic logic [8:0] on1(input logic [6:0] s);
        return {2'b10, s};
    endfunction

    task automatic push(input int c, input bit d, input logic [8:0] v, input string n);
        exp_t e;
        e.cyc = c; e.dut = d; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        int r;
        exp_t e;
        logic [8:0] got;
        rst_a = 1'b0; rst_b = 1'b0; div_a = 1'b0; div_b = 1'b0;
        s0_a = 4'h3; s1_a = 4'hA; s0_b = 4'h1; s1_b = 4'h2;
        repeat (2) @(negedge clk);
        r = cyc;
        for (int k = 0; k < 16; k++) push(r + k, 0, BLANK, "reset_blank");
        push(r + 16, 0, on0(7'b0110000), "first_show0");
        for (int i = 0; i <= 17; i++) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = e.dut ? {an0_b, an1_b, seg_b} : {an0_a, an1_a, seg_a};
                total++;
                if (got !== e.val) $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, got, e.val);
                else passed++;
            end
            if (i == 0) begin rst_a = 1'b1; rst_b = 1'b1; end
            @(negedge clk);
        end
    endtask

    task automatic test_swap();
        int t;
        exp_t e;
        logic [8:0] got;
        t = cyc;
        push(t + 1,  0, BLANK, "swap_off");
        push(t + 16, 0, BLANK, "dead_end1");
        push(t + 17, 0, on1(7'b0001000), "show1_A");
        push(t + 20, 0, on1(7'b0001000), "hold1_A");
        push(t + 21, 0, BLANK, "swap_back_off");
        push(t + 36, 0, BLANK, "dead_end0");
        push(t + 37, 0, on0(7'b0000000), "show0_8");
        for (int i = 0; i <= 38; i++) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = e.dut ? {an0_b, an1_b, seg_b} : {an0_a, an1_a, seg_a};
                total++;
                if (got !== e.val) $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, got, e.val);
                else passed++;
            end
            if (i == 0) begin s0_a = 4'h8; s1_a = 4'hA; end
            if (i == 0 || i == 20) div_a = ~div_a;
            @(negedge clk);
        end
    endtask

    task automatic test_latch();
        int t;
        exp_t e;
        logic [8:0] got;
        t = cyc;
        push(t + 37, 0, on0(7'b0110000), "show0_3");
        push(t + 45, 0, on0(7'b0110000), "no_tear");
        push(t + 86, 0, BLANK, "blank_before5");
        push(t + 87, 0, on0(7'b0010010), "show0_5");
        for (int i = 0; i <= 88; i++) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = e.dut ? {an0_b, an1_b, seg_b} : {an0_a, an1_a, seg_a};
                total++;
                if (got !== e.val) $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, got, e.val);
                else passed++;
            end
            if (i == 0) s0_a = 4'h3;
            if (i == 40) s0_a = 4'h5;
            if (i == 0 || i == 20 || i == 50 || i == 70) div_a = ~div_a;
            @(negedge clk);
        end
    endtask

    task automatic test_double_toggle();
        int t;
        exp_t e;
        logic [8:0] got;
        t = cyc;
        push(t + 1,  0, BLANK, "dbl_off");
        push(t + 6,  0, BLANK, "dbl_ignored");
        push(t + 16, 0, BLANK, "dbl_dead_end");
        push(t + 17, 0, on1(7'b0001000), "dbl_show1");
        push(t + 30, 0, on1(7'b0001000), "dbl_stay1");
        push(t + 32, 0, BLANK, "dbl_next_off");
        push(t + 48, 0, on0(7'b0010010), "dbl_show0");
        for (int i = 0; i <= 49; i++) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = e.dut ? {an0_b, an1_b, seg_b} : {an0_a, an1_a, seg_a};
                total++;
                if (got !== e.val) $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, got, e.val);
                else passed++;
            end
            if (i == 0 || i == 5 || i == 31) div_a = ~div_a;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        exp_t e;
        logic [8:0] got;
        t = cyc;
        push(t,      0, on0(7'b0010010), "pre_reset_show0");
        push(t + 1,  0, BLANK, "mid_reset_blank");
        push(t + 16, 0, BLANK, "mid_reset_dead_end");
        push(t + 17, 0, on0(7'b0010010), "mid_reset_show0");
        for (int i = 0; i <= 18; i++) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = e.dut ? {an0_b, an1_b, seg_b} : {an0_a, an1_a, seg_a};
                total++;
                if (got !== e.val) $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, got, e.val);
                else passed++;
            end
            if (i == 0) rst_a = 1'b0;
            if (i == 1) rst_a = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_lead_zero();
        int t;
        exp_t e;
        logic [8:0] got;
        logic [6:0] zero1;
`ifdef LEAD_ZERO_BLANK_EN
        zero1 = 7'b1111111;
`else
        zero1 = 7'b1000000;
`endif
        t = cyc;
        push(t + 17, 0, on1(zero1), "lead_zero_show1");
        push(t + 37, 0, on0(7'b1111000), "lead_show0_7");
        push(t + 57, 0, on1(7'b0100100), "lead_show1_2");
        for (int i = 0; i <= 58; i++) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = e.dut ? {an0_b, an1_b, seg_b} : {an0_a, an1_a, seg_a};
                total++;
                if (got !== e.val) $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, got, e.val);
                else passed++;
            end
            if (i == 0) begin s0_a = 4'h7; s1_a = 4'h0; end
            if (i == 25) s1_a = 4'h2;
            if (i == 0 || i == 20 || i == 40) div_a = ~div_a;
            @(negedge clk);
        end
    endtask

    task automatic test_zero_blank();
        int r;
        exp_t e;
        logic [8:0] got;
        rst_b = 1'b0; div_b = 1'b0; s0_b = 4'h1; s1_b = 4'h2;
        repeat (2) @(negedge clk);
        r = cyc;
        push(r, 1, BLANK, "zb_reset");
        // Swap at r+5k lands at r+5k+1, so each digit owns a 5-cycle slot.
        for (int c = r + 1; c <= r + 103; c++)
            push(c, 1, (((c - r - 1) / 5) % 2 == 1) ? on1(7'b0100100) : on0(7'b1111001), "zb_alt");
        for (int i = 0; i <= 104; i++) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = e.dut ? {an0_b, an1_b, seg_b} : {an0_a, an1_a, seg_a};
                total++;
                if (got !== e.val) $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, got, e.val);
                else passed++;
            end
            if (i == 0) rst_b = 1'b1;
            if (i > 0 && i <= 100 && i % 5 == 0) div_b = ~div_b;
            @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        test_reset();
        test_swap();
        test_latch();
        test_double_toggle();
        test_reset_mid();
        test_lead_zero();
        test_zero_blank();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            $display("FAIL %s never observed, expected %b at cyc %0d", e.name, e.val, e.cyc);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
